// File: rtl/int_source_conditioner_if.sv
// Request-line bundle between the board I/O and the interrupt source conditioner.
// The master drives the raw keys and enables. The slave returns the request pulses and the debounced levels.
interface int_source_conditioner_if;
    logic [2:0] key_in;
    logic [2:0] en;
    logic [2:0] intsrc;
    logic [2:0] key_level;

    modport master (output key_in, output en, input intsrc, input key_level);
    modport slave  (input key_in, input en, output intsrc, output key_level);
endinterface

// File: rtl/int_source_conditioner.sv
// Conditions three push-button lines into one-cycle CP0 interrupt requests: synchronise, debounce, detect rising edges, then gate with the enables.
// Optional build macro INTSRC_TIMER_EN: channel 0's request comes from a periodic timer instead of key_in[0].
module int_source_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = 20,
    parameter int TIMER_PERIOD    = 1000,
    parameter int TIMER_W         = 32
) (
    input logic                     clk,
    input logic                     rst,
    int_source_conditioner_if.slave bus
);

    if (DEBOUNCE_CYCLES < 2 || (CNT_W < 31 && (1 << CNT_W) <= DEBOUNCE_CYCLES)) begin : g_bad_debounce
        $error("int_source_conditioner: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end
    if (TIMER_PERIOD < 2 || TIMER_W < 1) begin : g_bad_timer
        $error("int_source_conditioner: TIMER_PERIOD must be >= 2");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       s1_p0;
    logic [2:0]       s2_p1;
    logic [2:0]       level_p2;
    logic [CNT_W-1:0] cnt_p2 [3];
    logic [2:0]       intsrc_p2;
    logic [2:0]       cnt_done;
    logic [2:0]       rise;
    logic [2:0]       intsrc_nxt;

    // A rise is a debounced 0->1 commit. The level is 0 and the synchronised input is 1.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_done[i] = (cnt_p2[i] == CNT_LAST);
            rise[i]     = cnt_done[i] && s2_p1[i] && !level_p2[i];
        end
    end

`ifdef INTSRC_TIMER_EN
    logic [TIMER_W-1:0] tcnt;
    logic               timer_hit;

    assign timer_hit = bus.en[0] && (tcnt == TIMER_W'(TIMER_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (!bus.en[0] || timer_hit) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TIMER_W'(1);
        end
    end

    always_comb begin
        intsrc_nxt    = bus.en & rise;
        intsrc_nxt[0] = timer_hit;
    end
`else
    always_comb begin
        intsrc_nxt = bus.en & rise;
    end
`endif

    // p0/p1: two-flop synchroniser. p2: debounced level, its counter and the request pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_p0     <= '0;
            s2_p1     <= '0;
            level_p2  <= '0;
            intsrc_p2 <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_p2[i] <= '0;
            end
        end else begin
            s1_p0     <= bus.key_in;
            s2_p1     <= s1_p0;
            intsrc_p2 <= intsrc_nxt;
            for (int i = 0; i < 3; i++) begin
                if (s2_p1[i] == level_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_done[i]) begin
                    level_p2[i] <= s2_p1[i];
                    cnt_p2[i]   <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.intsrc    = intsrc_p2;
    assign bus.key_level = level_p2;

endmodule
